// File: rtl/decode_ex_stage.sv
// RV32I decode stage and ID/EX pipeline register: control decode, immediate
// generation, load-use hazard detection and bubble insertion on stall/flush.
module decode_ex_stage #(
  parameter int XLEN            = 32,
  parameter bit LOAD_USE_DETECT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pcplus4_d,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic            pc_src_e,
  output logic [4:0]      a1_d,
  output logic [4:0]      a2_d,
  output logic            stall_f,
  output logic            stall_d,
  output logic            reg_write_e,
  output logic            mem_write_e,
  output logic            jump_e,
  output logic            branch_e,
  output logic            alu_src_e,
  output logic [1:0]      result_src_e,
  output logic [2:0]      alu_control_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] imm_ext_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pcplus4_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e
);

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_type_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BRNCH = 7'b1100011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_funct7b5;
  logic            w_reg_write;
  logic            w_mem_write;
  logic            w_jump;
  logic            w_branch;
  logic            w_alu_src;
  logic [1:0]      w_result_src;
  logic [1:0]      w_alu_op;
  logic [2:0]      w_alu_control;
  imm_type_t       w_imm_type;
  logic [XLEN-1:0] w_imm_ext;
  logic            w_lwstall;
  logic            w_flush_e;

  logic            r_reg_write;
  logic            r_mem_write;
  logic            r_jump;
  logic            r_branch;
  logic            r_alu_src;
  logic [1:0]      r_result_src;
  logic [2:0]      r_alu_control;
  logic [XLEN-1:0] r_rd1;
  logic [XLEN-1:0] r_rd2;
  logic [XLEN-1:0] r_imm_ext;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pcplus4;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;

  assign w_opcode   = instr_d[6:0];
  assign w_funct3   = instr_d[14:12];
  assign w_funct7b5 = instr_d[30];
  assign a1_d       = instr_d[19:15];
  assign a2_d       = instr_d[24:20];

  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_jump       = 1'b0;
    w_branch     = 1'b0;
    w_alu_src    = 1'b0;
    w_result_src = 2'b00;
    w_alu_op     = 2'b00;
    w_imm_type   = IMM_NONE;
    case (w_opcode)
      OP_LOAD: begin
        w_reg_write  = 1'b1;
        w_imm_type   = IMM_I;
        w_alu_src    = 1'b1;
        w_result_src = 2'b01;
      end
      OP_STORE: begin
        w_imm_type  = IMM_S;
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      OP_RTYPE: begin
        w_reg_write = 1'b1;
        w_alu_op    = 2'b10;
      end
      OP_BRNCH: begin
        w_imm_type = IMM_B;
        w_branch   = 1'b1;
        w_alu_op   = 2'b01;
      end
      OP_IALU: begin
        w_reg_write = 1'b1;
        w_imm_type  = IMM_I;
        w_alu_src   = 1'b1;
        w_alu_op    = 2'b10;
      end
      OP_JAL: begin
        w_reg_write  = 1'b1;
        w_imm_type   = IMM_J;
        w_result_src = 2'b10;
        w_jump       = 1'b1;
      end
      default: ;
    endcase
  end

  // Only R-type (op[5]=1) can select sub through funct7; addi with imm[10] set stays add.
  always_comb begin
    w_alu_control = ALU_ADD;
    case (w_alu_op)
      2'b00: w_alu_control = ALU_ADD;
      2'b01: w_alu_control = ALU_SUB;
      2'b10: begin
        case (w_funct3)
          3'b000:  w_alu_control = (w_opcode[5] && w_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  w_alu_control = ALU_SLT;
          3'b110:  w_alu_control = ALU_OR;
          3'b111:  w_alu_control = ALU_AND;
          default: w_alu_control = ALU_ADD;
        endcase
      end
      default: w_alu_control = ALU_ADD;
    endcase
  end

  always_comb begin
    w_imm_ext = '0;
    case (w_imm_type)
      IMM_I: w_imm_ext = {{(XLEN-12){instr_d[31]}}, instr_d[31:20]};
      IMM_S: w_imm_ext = {{(XLEN-12){instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
      IMM_B: w_imm_ext = {{(XLEN-12){instr_d[31]}}, instr_d[7], instr_d[30:25],
                          instr_d[11:8], 1'b0};
      IMM_J: w_imm_ext = {{(XLEN-20){instr_d[31]}}, instr_d[19:12], instr_d[20],
                          instr_d[30:21], 1'b0};
      default: w_imm_ext = '0;
    endcase
  end

  // A taken branch in EX discards the younger instructions, so it overrides the stall.
  assign w_lwstall = LOAD_USE_DETECT && (r_result_src == 2'b01) && (r_rd != 5'd0) &&
                     ((r_rd == a1_d) || (r_rd == a2_d));
  assign stall_f   = w_lwstall && !pc_src_e;
  assign stall_d   = w_lwstall && !pc_src_e;
  assign w_flush_e = w_lwstall || pc_src_e;

  always_ff @(posedge clk) begin
    if (rst || w_flush_e) begin
      r_reg_write   <= 1'b0;
      r_mem_write   <= 1'b0;
      r_jump        <= 1'b0;
      r_branch      <= 1'b0;
      r_alu_src     <= 1'b0;
      r_result_src  <= 2'b00;
      r_alu_control <= 3'b000;
      r_rd1         <= '0;
      r_rd2         <= '0;
      r_imm_ext     <= '0;
      r_pc          <= '0;
      r_pcplus4     <= '0;
      r_rs1         <= 5'd0;
      r_rs2         <= 5'd0;
      r_rd          <= 5'd0;
    end else begin
      r_reg_write   <= w_reg_write;
      r_mem_write   <= w_mem_write;
      r_jump        <= w_jump;
      r_branch      <= w_branch;
      r_alu_src     <= w_alu_src;
      r_result_src  <= w_result_src;
      r_alu_control <= w_alu_control;
      r_rd1         <= rd1_d;
      r_rd2         <= rd2_d;
      r_imm_ext     <= w_imm_ext;
      r_pc          <= pc_d;
      r_pcplus4     <= pcplus4_d;
      r_rs1         <= a1_d;
      r_rs2         <= a2_d;
      r_rd          <= instr_d[11:7];
    end
  end

  assign reg_write_e   = r_reg_write;
  assign mem_write_e   = r_mem_write;
  assign jump_e        = r_jump;
  assign branch_e      = r_branch;
  assign alu_src_e     = r_alu_src;
  assign result_src_e  = r_result_src;
  assign alu_control_e = r_alu_control;
  assign rd1_e         = r_rd1;
  assign rd2_e         = r_rd2;
  assign imm_ext_e     = r_imm_ext;
  assign pc_e          = r_pc;
  assign pcplus4_e     = r_pcplus4;
  assign rs1_e         = r_rs1;
  assign rs2_e         = r_rs2;
  assign rd_e          = r_rd;

endmodule

// File: tb/tb_decode_ex_stage.sv
// Bench for decode_ex_stage: decode vector table through a scoreboard, plus
// hand-written load-use, flush and reset corner sequences.
module tb_decode_ex_stage;

  logic        clk;
  logic        rst;
  logic [31:0] instr_d, pc_d, pcplus4_d, rd1_d, rd2_d;
  logic        pc_src_e;

  logic [4:0]  a1_d, a2_d;
  logic        stall_f, stall_d;
  logic        reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e;
  logic [1:0]  result_src_e;
  logic [2:0]  alu_control_e;
  logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pcplus4_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;

  // Second instance with hazard detection disabled; only its stalls are checked.
  logic [4:0]  n_a1_d, n_a2_d;
  logic        n_stall_f, n_stall_d;
  logic        n_reg_write_e, n_mem_write_e, n_jump_e, n_branch_e, n_alu_src_e;
  logic [1:0]  n_result_src_e;
  logic [2:0]  n_alu_control_e;
  logic [31:0] n_rd1_e, n_rd2_e, n_imm_ext_e, n_pc_e, n_pcplus4_e;
  logic [4:0]  n_rs1_e, n_rs2_e, n_rd_e;

  int testCount = 0;
  int failCount = 0;

  decode_ex_stage #(.XLEN(32), .LOAD_USE_DETECT(1'b1)) dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_src_e(pc_src_e),
    .a1_d(a1_d), .a2_d(a2_d), .stall_f(stall_f), .stall_d(stall_d),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .jump_e(jump_e),
    .branch_e(branch_e), .alu_src_e(alu_src_e), .result_src_e(result_src_e),
    .alu_control_e(alu_control_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .imm_ext_e(imm_ext_e), .pc_e(pc_e), .pcplus4_e(pcplus4_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e)
  );

  decode_ex_stage #(.XLEN(32), .LOAD_USE_DETECT(1'b0)) dutNoDetect (
    .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_src_e(pc_src_e),
    .a1_d(n_a1_d), .a2_d(n_a2_d), .stall_f(n_stall_f), .stall_d(n_stall_d),
    .reg_write_e(n_reg_write_e), .mem_write_e(n_mem_write_e), .jump_e(n_jump_e),
    .branch_e(n_branch_e), .alu_src_e(n_alu_src_e), .result_src_e(n_result_src_e),
    .alu_control_e(n_alu_control_e), .rd1_e(n_rd1_e), .rd2_e(n_rd2_e),
    .imm_ext_e(n_imm_ext_e), .pc_e(n_pc_e), .pcplus4_e(n_pcplus4_e),
    .rs1_e(n_rs1_e), .rs2_e(n_rs2_e), .rd_e(n_rd_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        rw, mw, jmp, br, asrc;
    logic [1:0]  rsrc;
    logic [2:0]  actl;
    logic [31:0] imm;
    logic        chkImm;
    logic [4:0]  rs1, rs2, rd;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] pc, pcp4, rd1, rd2;
  } sb_t;

  localparam int NV = 14;
  vec_t vecs[NV];
  sb_t  sbQueue[$];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    sb_t e;
    instr_d   = v.instr;
    pc_d      = 32'h10 + 32'(idx) * 4;
    pcplus4_d = pc_d + 32'd4;
    rd1_d     = $urandom;
    rd2_d     = $urandom;
    e.v = v; e.pc = pc_d; e.pcp4 = pcplus4_d; e.rd1 = rd1_d; e.rd2 = rd2_d;
    sbQueue.push_back(e);
    #1;
    checkVal($sformatf("v%0d a1_d", idx), 32'(a1_d), 32'(v.rs1));
    checkVal($sformatf("v%0d a2_d", idx), 32'(a2_d), 32'(v.rs2));
    checkVal($sformatf("v%0d stall_d", idx), 32'(stall_d), 32'd0);
  endtask

  task automatic checkOutput(input int idx);
    sb_t e;
    if (sbQueue.size() == 0) begin
      checkVal($sformatf("v%0d scoreboard empty", idx), 32'd1, 32'd0);
      return;
    end
    e = sbQueue.pop_front();
    checkVal($sformatf("v%0d reg_write_e", idx), 32'(reg_write_e), 32'(e.v.rw));
    checkVal($sformatf("v%0d mem_write_e", idx), 32'(mem_write_e), 32'(e.v.mw));
    checkVal($sformatf("v%0d jump_e", idx), 32'(jump_e), 32'(e.v.jmp));
    checkVal($sformatf("v%0d branch_e", idx), 32'(branch_e), 32'(e.v.br));
    checkVal($sformatf("v%0d alu_src_e", idx), 32'(alu_src_e), 32'(e.v.asrc));
    checkVal($sformatf("v%0d result_src_e", idx), 32'(result_src_e), 32'(e.v.rsrc));
    checkVal($sformatf("v%0d alu_control_e", idx), 32'(alu_control_e), 32'(e.v.actl));
    if (e.v.chkImm)
      checkVal($sformatf("v%0d imm_ext_e", idx), imm_ext_e, e.v.imm);
    checkVal($sformatf("v%0d rs1_e", idx), 32'(rs1_e), 32'(e.v.rs1));
    checkVal($sformatf("v%0d rs2_e", idx), 32'(rs2_e), 32'(e.v.rs2));
    checkVal($sformatf("v%0d rd_e", idx), 32'(rd_e), 32'(e.v.rd));
    checkVal($sformatf("v%0d pc_e", idx), pc_e, e.pc);
    checkVal($sformatf("v%0d pcplus4_e", idx), pcplus4_e, e.pcp4);
    checkVal($sformatf("v%0d rd1_e", idx), rd1_e, e.rd1);
    checkVal($sformatf("v%0d rd2_e", idx), rd2_e, e.rd2);
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, " reg_write_e"}, 32'(reg_write_e), 32'd0);
    checkVal({tag, " mem_write_e"}, 32'(mem_write_e), 32'd0);
    checkVal({tag, " jump_e"}, 32'(jump_e), 32'd0);
    checkVal({tag, " branch_e"}, 32'(branch_e), 32'd0);
    checkVal({tag, " alu_src_e"}, 32'(alu_src_e), 32'd0);
    checkVal({tag, " result_src_e"}, 32'(result_src_e), 32'd0);
    checkVal({tag, " alu_control_e"}, 32'(alu_control_e), 32'd0);
    checkVal({tag, " rd1_e"}, rd1_e, 32'd0);
    checkVal({tag, " rd2_e"}, rd2_e, 32'd0);
    checkVal({tag, " imm_ext_e"}, imm_ext_e, 32'd0);
    checkVal({tag, " pc_e"}, pc_e, 32'd0);
    checkVal({tag, " pcplus4_e"}, pcplus4_e, 32'd0);
    checkVal({tag, " rs1_e"}, 32'(rs1_e), 32'd0);
    checkVal({tag, " rs2_e"}, 32'(rs2_e), 32'd0);
    checkVal({tag, " rd_e"}, 32'(rd_e), 32'd0);
    checkVal({tag, " stall_f"}, 32'(stall_f), 32'd0);
    checkVal({tag, " stall_d"}, 32'(stall_d), 32'd0);
  endtask

  task automatic driveInstr(input logic [31:0] instr);
    instr_d   = instr;
    pc_d      = 32'h100;
    pcplus4_d = 32'h104;
    rd1_d     = 32'hAAAA5555;
    rd2_d     = 32'h5555AAAA;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [31:0] LW_X6  = 32'h0082A303;
  localparam logic [31:0] ADD_X7 = 32'h005303B3;
  localparam logic [31:0] SW_X7  = 32'h00712623;
  localparam logic [31:0] LW_X0  = 32'h0000A003;
  localparam logic [31:0] ADDI_5 = 32'hFFD00293;

  initial begin
    //          instr          rw mw j  b  as rsrc   actl    imm           chk rs1 rs2 rd
    vecs[0]  = '{ADDI_5,       1, 0, 0, 0, 1, 2'b00, 3'b000, 32'hFFFFFFFD, 1, 0,  29, 5};
    vecs[1]  = '{LW_X6,        1, 0, 0, 0, 1, 2'b01, 3'b000, 32'h00000008, 1, 5,  8,  6};
    vecs[2]  = '{SW_X7,        0, 1, 0, 0, 1, 2'b00, 3'b000, 32'h0000000C, 1, 2,  7,  12};
    vecs[3]  = '{32'h40A48433, 1, 0, 0, 0, 0, 2'b00, 3'b001, 32'h0,        0, 9,  10, 8};
    vecs[4]  = '{32'h00D675B3, 1, 0, 0, 0, 0, 2'b00, 3'b010, 32'h0,        0, 12, 13, 11};
    vecs[5]  = '{32'h003160B3, 1, 0, 0, 0, 0, 2'b00, 3'b011, 32'h0,        0, 2,  3,  1};
    vecs[6]  = '{32'hFFF2A213, 1, 0, 0, 0, 1, 2'b00, 3'b101, 32'hFFFFFFFF, 1, 5,  31, 4};
    vecs[7]  = '{32'h40008093, 1, 0, 0, 0, 1, 2'b00, 3'b000, 32'h00000400, 1, 1,  0,  1};
    vecs[8]  = '{32'hFE208CE3, 0, 0, 0, 1, 0, 2'b00, 3'b001, 32'hFFFFFFF8, 1, 1,  2,  25};
    vecs[9]  = '{32'hFFDFF0EF, 1, 0, 1, 0, 0, 2'b10, 3'b000, 32'hFFFFFFFC, 1, 31, 29, 1};
    vecs[10] = '{32'h010000EF, 1, 0, 1, 0, 0, 2'b10, 3'b000, 32'h00000010, 1, 0,  16, 1};
    vecs[11] = '{32'hFE532E23, 0, 1, 0, 0, 1, 2'b00, 3'b000, 32'hFFFFFFFC, 1, 6,  5,  28};
    vecs[12] = '{32'h00000000, 0, 0, 0, 0, 0, 2'b00, 3'b000, 32'h0,        0, 0,  0,  0};
    vecs[13] = '{32'h12345037, 0, 0, 0, 0, 0, 2'b00, 3'b000, 32'h0,        0, 8,  3,  0};

    rst = 1'b1;
    pc_src_e = 1'b0;
    driveInstr(ADDI_5);
    pc_d = 32'h10; pcplus4_d = 32'h14;
    @(negedge clk);
    stepCycle();
    stepCycle();
    checkAllZero("reset");
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i], i);
      stepCycle();
      checkOutput(i);
    end

    // Load-use: lw x6 in E, add x7,x6,x5 in D; IF/ID holds add while stalled.
    driveInstr(LW_X6);
    stepCycle();
    driveInstr(ADD_X7);
    #1;
    checkVal("loaduse stall_f", 32'(stall_f), 32'd1);
    checkVal("loaduse stall_d", 32'(stall_d), 32'd1);
    checkVal("nodetect stall_f", 32'(n_stall_f), 32'd0);
    checkVal("nodetect stall_d", 32'(n_stall_d), 32'd0);
    stepCycle();
    checkVal("bubble reg_write_e", 32'(reg_write_e), 32'd0);
    checkVal("bubble rd_e", 32'(rd_e), 32'd0);
    checkVal("bubble result_src_e", 32'(result_src_e), 32'd0);
    checkVal("bubble stall_f", 32'(stall_f), 32'd0);
    checkVal("bubble stall_d", 32'(stall_d), 32'd0);
    checkVal("nodetect add rd_e", 32'(n_rd_e), 32'd7);
    stepCycle();
    checkVal("after stall reg_write_e", 32'(reg_write_e), 32'd1);
    checkVal("after stall alu_control_e", 32'(alu_control_e), 32'd0);
    checkVal("after stall rs1_e", 32'(rs1_e), 32'd6);
    checkVal("after stall rs2_e", 32'(rs2_e), 32'd5);
    checkVal("after stall rd_e", 32'(rd_e), 32'd7);

    // Flush a store in D with a taken branch in EX.
    driveInstr(SW_X7);
    pc_src_e = 1'b1;
    #1;
    checkVal("flush stall_f", 32'(stall_f), 32'd0);
    checkVal("flush stall_d", 32'(stall_d), 32'd0);
    stepCycle();
    pc_src_e = 1'b0;
    checkAllZero("flush");

    // lw x0 in E never stalls a reader of x0.
    driveInstr(LW_X0);
    stepCycle();
    checkVal("lw x0 result_src_e", 32'(result_src_e), 32'd1);
    driveInstr(ADDI_5);
    #1;
    checkVal("x0 stall_f", 32'(stall_f), 32'd0);
    checkVal("x0 stall_d", 32'(stall_d), 32'd0);
    stepCycle();
    checkVal("x0 no bubble rd_e", 32'(rd_e), 32'd5);

    // Load-use coinciding with a taken branch: flush wins, stalls suppressed.
    driveInstr(LW_X6);
    stepCycle();
    driveInstr(ADD_X7);
    pc_src_e = 1'b1;
    #1;
    checkVal("lw+flush stall_f", 32'(stall_f), 32'd0);
    checkVal("lw+flush stall_d", 32'(stall_d), 32'd0);
    stepCycle();
    pc_src_e = 1'b0;
    checkVal("lw+flush reg_write_e", 32'(reg_write_e), 32'd0);
    checkVal("lw+flush rd_e", 32'(rd_e), 32'd0);

    // Reset asserted while a load-use stall is pending.
    driveInstr(LW_X6);
    stepCycle();
    driveInstr(ADD_X7);
    #1;
    checkVal("pre-reset stall_f", 32'(stall_f), 32'd1);
    rst = 1'b1;
    stepCycle();
    checkAllZero("midstall reset");
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/decode_ex_stage.md
Name: decode_ex_stage

Overview:
- Decode stage of the 5-stage RV32I pipeline plus the ID/EX pipeline register.
- Drives the register-file read addresses from the fetched instruction, decodes control signals, and generates the sign-extended immediate.
- Detects load-use hazards and registers everything into the EX stage, inserting bubbles on stall or flush.
- Sits between the IF/ID register and the execute stage.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- LOAD_USE_DETECT, 1, 1 enables load-use hazard detection; 0 ties both stall outputs to 0.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_d  in  32  instruction held in IF/ID.
- pc_d, pcplus4_d  in  32 each  PC and PC+4 of instr_d.
- rd1_d, rd2_d  in  32 each  register-file read data for a1_d/a2_d.
- pc_src_e  in  1  taken branch/jump resolved in EX; flushes ID/EX.
- a1_d, a2_d  out  5 each  register-file read addresses: instr_d[19:15], instr_d[24:20]; combinational.
- stall_f, stall_d  out  1 each  freeze PC and IF/ID; combinational.
- reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e  out  1 each  registered controls.
- result_src_e  out  2  00 ALU, 01 memory, 10 PC+4.
- alu_control_e  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- rd1_e, rd2_e, imm_ext_e, pc_e, pcplus4_e  out  32 each  registered data.
- rs1_e, rs2_e, rd_e  out  5 each  registered register indices (for forwarding).

Behaviour:

Opcode decode (combinational on instr_d). Columns: reg_write, imm type, alu_src, mem_write, result_src, branch, ALUOp, jump.
- 0000011 lw: 1, I, 1, 0, 01, 0, 00, 0.
- 0100011 sw: 0, S, 1, 1, 00, 0, 00, 0.
- 0110011 R-type: 1, –, 0, 0, 00, 0, 10, 0.
- 1100011 beq: 0, B, 0, 0, 00, 1, 01, 0.
- 0010011 I-ALU: 1, I, 1, 0, 00, 0, 10, 0.
- 1101111 jal: 1, J, 0, 0, 10, 0, 00, 1.
- Any other opcode (including 0x00000000): all controls 0, i.e. a NOP.

ALU control:
- ALUOp 00 -> add.
- ALUOp 01 -> sub.
- ALUOp 10, decoded on funct3:
  - 000: sub if op[5] and funct7[5], else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Any other funct3: add.

Immediates (sign bit is instr[31]; X = don't care):
- I: sext(instr[31:20]).
- S: sext({instr[31:25], instr[11:7]}).
- B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
- J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- R-type / unknown: X.

Hazard logic:
- lwstall = LOAD_USE_DETECT & (result_src_e == 01) & (rd_e != 0) & ((rd_e == a1_d) | (rd_e == a2_d)).
- The comparison uses a1_d/a2_d for every opcode (conservative).
- stall_f = stall_d = lwstall & ~pc_src_e.
- flush_e = lwstall | pc_src_e.

ID/EX register (rising edge, priority order):
1. rst: all *_e outputs cleared to 0.
2. Else flush_e: all *_e outputs loaded with 0 (bubble = NOP with rd_e = 0).
3. Else: all *_e outputs loaded from the decode results, rd1_d/rd2_d, pc_d, pcplus4_d, a1_d, a2_d, and instr_d[11:7].

Timing and boundary rules:
- Latency is 1 cycle from D to E.
- The register file writes on the falling edge, so rd1_d/rd2_d already reflect a same-cycle writeback; no internal bypass is required.
- A bubble clears result_src_e, so a stall lasts exactly one cycle.
- rst mid-stall: outputs zero on the next edge. stall_f/stall_d are combinational and go to 0 once result_src_e has been cleared.
- lwstall and pc_src_e together: the flush occurs and stalls are suppressed.

Test Plan:
- Reset: hold rst=1 for 2 cycles with instr_d=0xFFD00293 -> every *_e output is 0; stall_f=stall_d=0.
- addi x5,x0,-3 (instr_d=0xFFD00293, pc_d=0x10) -> next cycle:
  - controls: reg_write_e=1, alu_src_e=1, alu_control_e=000, result_src_e=00.
  - data: imm_ext_e=0xFFFFFFFD, rd_e=5, pc_e=0x10, pcplus4_e=0x14.
  - combinationally: a1_d=0, a2_d=29.
- Load-use: lw x6,8(x5) (0x0082A303) then add x7,x6,x5 (0x005303B3) ->
  - with lw in E and add in D: stall_f=stall_d=1.
  - next cycle: E holds a bubble (reg_write_e=0, rd_e=0), stalls 0.
  - following cycle: E holds add with alu_control_e=000, rs1_e=6, rs2_e=5, rd_e=7.
- Flush: pc_src_e=1 while instr_d is sw -> next cycle mem_write_e=0 and all controls 0; stall outputs stay 0.
- beq x1,x2,-8 (0xFE208CE3) -> branch_e=1, alu_control_e=001, imm_ext_e=0xFFFFFFF8, reg_write_e=0, rs1_e=1, rs2_e=2.
- lw with rd=x0 in E, D reads x0 -> no stall.
- With LOAD_USE_DETECT=0, rerun the load-use scenario -> stalls never assert.
